// File: rtl/cu_mc.sv
// Multi-cycle control unit: fetch / execute / memory-wait sequencer that decodes the
// instruction register into datapath, register-file and memory/IO control strobes.

package mycpu_pkg;

    typedef enum logic [6:0] {
        OP_MOVA = 7'h00, OP_INC  = 7'h01, OP_ADD  = 7'h02, OP_MUL  = 7'h03,
        OP_SUB  = 7'h04, OP_DEC  = 7'h05, OP_AND  = 7'h06, OP_OR   = 7'h07,
        OP_XOR  = 7'h08, OP_NOT  = 7'h09, OP_MOVB = 7'h0A, OP_SHR  = 7'h0B,
        OP_SHL  = 7'h0C, OP_USR  = 7'h0D,
        OP_SRA  = 7'h10, OP_SLA  = 7'h11, OP_LDI  = 7'h12, OP_ADI  = 7'h13,
        OP_LD   = 7'h20, OP_ST   = 7'h21, OP_IOR  = 7'h22, OP_IOW  = 7'h23,
        OP_BRZ  = 7'h30, OP_BRN  = 7'h31, OP_JMP  = 7'h32,
        OP_HAL  = 7'h3F
    } opcode_t;

    typedef enum logic [3:0] {
        FMOVA, FINC, FADD, FMUL, FSUB, FDEC, FAND, FOR,
        FXOR, FNOT, FMOVB, FSHR, FSHL, FUSR, FSRA, FSLA
    } fs_t;

endpackage

module cu_mc #(
    parameter int IW       = 16,
    parameter int RAW      = 3,
    parameter int RSW      = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IW-1:0]    ins_in,
    input  logic [1:0]       nz_in,
    input  logic             mem_rdy_in,
    input  logic             run_in,
    output logic             il_out,
    output logic [1:0]       ps_out,
    output logic             rw_out,
    output logic [3*RSW-1:0] rs_out,
    output logic [3:0]       mx_out,
    output mycpu_pkg::fs_t   fs_out,
    output logic             wen_out,
    output logic             iom_out,
    output logic             mreq_out,
    output logic             halted_out,
    output logic             fault_out
);
    import mycpu_pkg::*;

    if (RSW < RAW) begin : g_bad_rsw
        $error("cu_mc: RSW (%0d) must be >= RAW (%0d)", RSW, RAW);
    end
    if (IW < 7 + 3*RAW) begin : g_bad_iw
        $error("cu_mc: IW (%0d) must be >= 7 + 3*RAW (%0d)", IW, 7 + 3*RAW);
    end

    localparam int WCW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX);

    typedef enum logic [2:0] {S_RST, S_INF, S_EX0, S_MEMW, S_HLT, S_FLT} state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wcnt, wcnt_nxt;
    opcode_t        op;
    logic [3*RSW-1:0] rs_fields;
    logic           is_mem, is_io, is_rd, is_wr, timeout;
    logic           unused_ins;

    assign op        = opcode_t'(ins_in[IW-1 -: 7]);
    assign rs_fields = {RSW'(ins_in[3*RAW-1 -: RAW]),
                        RSW'(ins_in[2*RAW-1 -: RAW]),
                        RSW'(ins_in[RAW-1:0])};
    assign is_mem     = op inside {OP_LD, OP_ST, OP_IOR, OP_IOW};
    assign is_io      = op inside {OP_IOR, OP_IOW};
    assign is_rd      = op inside {OP_LD, OP_IOR};
    assign is_wr      = op inside {OP_ST, OP_IOW};
    assign timeout    = (wcnt == WAIT_LAST);
    assign unused_ins = ^ins_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        il_out     = 1'b0;
        ps_out     = 2'b00;
        rw_out     = 1'b0;
        rs_out     = '0;
        mx_out     = 4'b0000;
        fs_out     = FMOVA;
        wen_out    = 1'b1;
        iom_out    = 1'b0;
        mreq_out   = 1'b0;
        halted_out = 1'b0;
        fault_out  = 1'b0;
        state_nxt  = S_FLT;
        wcnt_nxt   = '0;

        case (state)
            S_RST: state_nxt = S_INF;

            S_INF: begin
                mreq_out = 1'b1;
                il_out   = mem_rdy_in;
                if (mem_rdy_in) begin
                    state_nxt = S_EX0;
                end else if (!timeout) begin
                    state_nxt = S_INF;
                    wcnt_nxt  = wcnt + WCW'(1);
                end
            end

            // MEMW re-decodes the held instruction; only memory ops may stay here.
            S_EX0, S_MEMW: begin
                rs_out = rs_fields;
                if (is_mem) begin
                    mreq_out = 1'b1;
                    iom_out  = is_io;
                    mx_out   = (op == OP_LD) ? 4'b0010 : 4'b0000;
                    if (mem_rdy_in) begin
                        ps_out    = 2'b01;
                        rw_out    = is_rd;
                        wen_out   = !is_wr;
                        state_nxt = S_INF;
                    end else if (state == S_EX0) begin
                        state_nxt = S_MEMW;
                    end else if (!timeout) begin
                        state_nxt = S_MEMW;
                        wcnt_nxt  = wcnt + WCW'(1);
                    end
                end else if (state == S_EX0) begin
                    case (op)
                        // ALU opcodes are encoded to match the fs_t ordinals.
                        OP_MOVA, OP_INC, OP_ADD, OP_MUL, OP_SUB, OP_DEC, OP_AND,
                        OP_OR, OP_XOR, OP_NOT, OP_MOVB, OP_SHR, OP_SHL, OP_USR: begin
                            ps_out    = 2'b01;
                            rw_out    = 1'b1;
                            mx_out    = 4'b0100;
                            fs_out    = fs_t'(op[3:0]);
                            state_nxt = S_INF;
                        end
                        OP_SRA, OP_SLA, OP_LDI, OP_ADI: begin
                            ps_out    = 2'b01;
                            rw_out    = 1'b1;
                            mx_out    = 4'b1100;
                            state_nxt = S_INF;
                            case (op)
                                OP_SRA:  fs_out = FSRA;
                                OP_SLA:  fs_out = FSLA;
                                OP_LDI:  fs_out = FMOVB;
                                default: fs_out = FADD;
                            endcase
                        end
                        OP_BRZ: begin
                            ps_out    = nz_in[0] ? 2'b10 : 2'b01;
                            state_nxt = S_INF;
                        end
                        OP_BRN: begin
                            ps_out    = nz_in[1] ? 2'b10 : 2'b01;
                            state_nxt = S_INF;
                        end
                        OP_JMP: begin
                            ps_out    = 2'b11;
                            state_nxt = S_INF;
                        end
                        OP_HAL:  state_nxt = S_HLT;
                        default: state_nxt = S_FLT;
                    endcase
                end
            end

            S_HLT: begin
                halted_out = 1'b1;
                state_nxt  = run_in ? S_INF : S_HLT;
            end

            S_FLT: begin
                fault_out = 1'b1;
                state_nxt = S_FLT;
            end

            default: state_nxt = S_FLT;
        endcase
    end

endmodule

// File: tb/tb_cu_mc.sv
// Bench for cu_mc: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a phase-level reference model of the sequencer.

module tb_cu_mc;
    import mycpu_pkg::*;

    localparam int WAIT_MAX = 15;
    localparam int K_ALU = 0, K_IMM = 1, K_MEM = 2, K_BR = 3, K_HAL = 4, K_BAD = 5;

    typedef enum {P_RESET, P_FETCH, P_EXEC, P_WAIT, P_HALT, P_FAULT} phase_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] ins = '0;
    logic [19:0] ins2 = '0;
    logic [1:0]  nz = '0;
    logic        rdy = 1'b0, run = 1'b0;

    logic        il, rw, wen, iom, mreq, halted, fault;
    logic [1:0]  ps;
    logic [11:0] rs;
    logic [3:0]  mx;
    fs_t         fs;

    logic        il2, rw2, wen2, iom2, mreq2, halted2, fault2;
    logic [1:0]  ps2;
    logic [14:0] rs2;
    logic [3:0]  mx2;
    fs_t         fs2;

    cu_mc #(.IW(16), .RAW(3), .RSW(4), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .ins_in(ins), .nz_in(nz), .mem_rdy_in(rdy), .run_in(run),
        .il_out(il), .ps_out(ps), .rw_out(rw), .rs_out(rs), .mx_out(mx), .fs_out(fs),
        .wen_out(wen), .iom_out(iom), .mreq_out(mreq), .halted_out(halted), .fault_out(fault)
    );

    cu_mc #(.IW(20), .RAW(4), .RSW(5), .WAIT_MAX(WAIT_MAX)) dut_w (
        .clk(clk), .rst_n(rst_n), .ins_in(ins2), .nz_in(nz), .mem_rdy_in(rdy), .run_in(run),
        .il_out(il2), .ps_out(ps2), .rw_out(rw2), .rs_out(rs2), .mx_out(mx2), .fs_out(fs2),
        .wen_out(wen2), .iom_out(iom2), .mreq_out(mreq2), .halted_out(halted2), .fault_out(fault2)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction classes expressed as lookup tables.
    logic [6:0] alu_ops [14] = '{OP_MOVA, OP_INC, OP_ADD, OP_MUL, OP_SUB, OP_DEC, OP_AND,
                                 OP_OR, OP_XOR, OP_NOT, OP_MOVB, OP_SHR, OP_SHL, OP_USR};
    fs_t        alu_fns [14] = '{FMOVA, FINC, FADD, FMUL, FSUB, FDEC, FAND,
                                 FOR, FXOR, FNOT, FMOVB, FSHR, FSHL, FUSR};
    logic [6:0] imm_ops [4]  = '{OP_SRA, OP_SLA, OP_LDI, OP_ADI};
    fs_t        imm_fns [4]  = '{FSRA, FSLA, FMOVB, FADD};
    logic [6:0] mem_ops [4]  = '{OP_LD, OP_ST, OP_IOR, OP_IOW};
    logic [6:0] br_ops  [3]  = '{OP_BRZ, OP_BRN, OP_JMP};
    logic [6:0] bad_ops [4]  = '{7'h7F, 7'h0E, 7'h14, 7'h40};

    function automatic int kind(input logic [6:0] op, output fs_t f);
        f = FMOVA;
        for (int i = 0; i < 14; i++) if (alu_ops[i] == op) begin f = alu_fns[i]; return K_ALU; end
        for (int i = 0; i < 4; i++)  if (imm_ops[i] == op) begin f = imm_fns[i]; return K_IMM; end
        for (int i = 0; i < 4; i++)  if (mem_ops[i] == op) return K_MEM;
        for (int i = 0; i < 3; i++)  if (br_ops[i] == op)  return K_BR;
        if (op == OP_HAL) return K_HAL;
        return K_BAD;
    endfunction

    int   cur_kind;
    fs_t  cur_fs;
    always_comb cur_kind = kind(ins[15:9], cur_fs);

    // Reference model: which phase the sequencer is in and how long it has waited.
    phase_t ph = P_RESET;
    int     waited = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph     <= P_RESET;
            waited <= 0;
        end else begin
            case (ph)
                P_RESET: begin ph <= P_FETCH; waited <= 0; end
                P_FETCH:
                    if (rdy)                     ph <= P_EXEC;
                    else if (waited == WAIT_MAX) ph <= P_FAULT;
                    else                         waited <= waited + 1;
                P_EXEC:
                    case (cur_kind)
                        K_ALU, K_IMM, K_BR: begin ph <= P_FETCH; waited <= 0; end
                        K_MEM: begin ph <= rdy ? P_FETCH : P_WAIT; waited <= 0; end
                        K_HAL: ph <= P_HALT;
                        default: ph <= P_FAULT;
                    endcase
                P_WAIT:
                    if (cur_kind != K_MEM)       ph <= P_FAULT;
                    else if (rdy)                begin ph <= P_FETCH; waited <= 0; end
                    else if (waited == WAIT_MAX) ph <= P_FAULT;
                    else                         waited <= waited + 1;
                P_HALT: if (run) begin ph <= P_FETCH; waited <= 0; end
                default: ph <= P_FAULT;
            endcase
        end
    end

    logic        e_il, e_rw, e_wen, e_iom, e_mreq, e_halt, e_fault;
    logic [1:0]  e_ps;
    logic [11:0] e_rs;
    logic [14:0] e_rs2;
    logic [3:0]  e_mx;
    fs_t         e_fs;

    initial forever begin
        @(negedge clk);
        #2;
        e_il = 0; e_ps = 0; e_rw = 0; e_rs = 0; e_rs2 = 0; e_mx = 0; e_fs = FMOVA;
        e_wen = 1; e_iom = 0; e_mreq = 0; e_halt = 0; e_fault = 0;
        case (ph)
            P_FETCH: begin e_mreq = 1; e_il = rdy; end
            P_EXEC, P_WAIT: begin
                e_rs  = {1'b0, ins[8:6], 1'b0, ins[5:3], 1'b0, ins[2:0]};
                e_rs2 = {1'b0, ins2[11:8], 1'b0, ins2[7:4], 1'b0, ins2[3:0]};
                if (cur_kind == K_MEM) begin
                    e_mreq = 1;
                    e_iom  = (ins[15:9] == OP_IOR) || (ins[15:9] == OP_IOW);
                    e_mx   = (ins[15:9] == OP_LD) ? 4'd2 : 4'd0;
                    if (rdy) begin
                        e_ps  = 1;
                        e_rw  = (ins[15:9] == OP_LD) || (ins[15:9] == OP_IOR);
                        e_wen = !((ins[15:9] == OP_ST) || (ins[15:9] == OP_IOW));
                    end
                end else if (ph == P_EXEC) begin
                    if (cur_kind == K_ALU || cur_kind == K_IMM) begin
                        e_ps = 1; e_rw = 1; e_fs = cur_fs;
                        e_mx = (cur_kind == K_ALU) ? 4'd4 : 4'd12;
                    end else if (cur_kind == K_BR) begin
                        if (ins[15:9] == OP_JMP)      e_ps = 3;
                        else if (ins[15:9] == OP_BRZ) e_ps = nz[0] ? 2 : 1;
                        else                          e_ps = nz[1] ? 2 : 1;
                    end
                end
            end
            P_HALT:  e_halt = 1;
            P_FAULT: e_fault = 1;
            default: ;
        endcase
        check("il", il, e_il);       check("ps", ps, e_ps);       check("rw", rw, e_rw);
        check("rs", rs, e_rs);       check("mx", mx, e_mx);       check("fs", fs, e_fs);
        check("wen", wen, e_wen);    check("iom", iom, e_iom);    check("mreq", mreq, e_mreq);
        check("halted", halted, e_halt);  check("fault", fault, e_fault);
        check("rs_wide", rs2, e_rs2);     check("mreq_wide", mreq2, e_mreq);
    end

    task automatic cyc(input logic [6:0] op, input logic [8:0] f, input logic r,
                       input logic [1:0] z, input logic rn);
        @(negedge clk);
        ins  = {op, f};
        ins2 = {op, 1'b0, 1'b1, f[8:6], 1'b0, f[5:3], 1'b1, f[2:0]};
        rdy = r; nz = z; run = rn;
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        int stall, fault_cycles, sel;
        logic [6:0] op;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD R1,R2,R3 with ready tied high
        cyc(OP_ADD, 9'o123, 1, 0, 0);
        check("rst_cycle_mreq", mreq, 0);  check("rst_cycle_il", il, 0);
        check("model_reset_phase", ph, P_RESET);
        cyc(OP_ADD, 9'o123, 1, 0, 0);
        check("inf_il", il, 1);            check("inf_mreq", mreq, 1);
        cyc(OP_ADD, 9'o123, 1, 0, 0);
        check("add_rs", rs, 12'h123);      check("add_mx", mx, 4'b0100);
        check("add_fs", fs, FADD);         check("add_rw", rw, 1);
        check("add_ps", ps, 2'b01);        check("add_rs_wide", rs2, 15'h244B);

        // LD with ready delayed: EX0 plus three waiting MEMW cycles
        cyc(OP_LD, 9'o456, 1, 0, 0);
        check("ld_inf_il", il, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(OP_LD, 9'o456, 0, 0, 0);
            check("ld_wait_rw", rw, 0);    check("ld_wait_ps", ps, 2'b00);
            check("ld_wait_mx", mx, 4'b0010);
        end
        cyc(OP_LD, 9'o456, 1, 0, 0);
        check("ld_commit_rw", rw, 1);      check("ld_commit_ps", ps, 2'b01);

        // Branches
        cyc(OP_BRZ, 0, 1, 2'b01, 0);  cyc(OP_BRZ, 0, 1, 2'b01, 0);
        check("brz_taken", ps, 2'b10);
        cyc(OP_BRZ, 0, 1, 2'b10, 0);  cyc(OP_BRZ, 0, 1, 2'b10, 0);
        check("brz_not_taken", ps, 2'b01);
        cyc(OP_BRN, 0, 1, 2'b10, 0);  cyc(OP_BRN, 0, 1, 2'b10, 0);
        check("brn_taken", ps, 2'b10);

        // Halt and resume
        cyc(OP_HAL, 0, 1, 0, 0);
        cyc(OP_HAL, 0, 1, 0, 0);
        check("hal_ex0_halted", halted, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(OP_HAL, 0, 1, 0, 0);
            check("hlt_halted", halted, 1);
        end
        cyc(OP_HAL, 0, 1, 0, 1);
        check("hlt_run_cycle", halted, 1);
        cyc(OP_ADD, 9'o123, 1, 0, 0);
        check("resume_il", il, 1);         check("resume_halted", halted, 0);
        cyc(OP_ADD, 9'o123, 0, 0, 0);

        // Fetch timeout: 16 waiting INF cycles, then FLT
        for (int i = 0; i < 16; i++) cyc(OP_ADD, 0, 0, 0, 0);
        check("timeout_last_inf_fault", fault, 0);
        cyc(OP_ADD, 0, 0, 0, 0);
        check("timeout_fault", fault, 1);  check("model_fault_phase", ph, P_FAULT);
        for (int i = 0; i < 3; i++) begin
            cyc(OP_ADD, 0, 1, 0, 1);
            check("fault_sticky", fault, 1);
        end
        do_reset();

        // Reset during ST in MEMW abandons the write
        cyc(OP_ST, 9'o777, 1, 0, 0);
        cyc(OP_ST, 9'o777, 1, 0, 0);
        cyc(OP_ST, 9'o777, 0, 0, 0);
        check("st_ex0_wen", wen, 1);
        cyc(OP_ST, 9'o777, 0, 0, 0);
        check("st_memw_wen", wen, 1);      check("st_memw_mreq", mreq, 1);
        @(negedge clk); rst_n = 1'b0; rdy = 1'b1; #3;
        check("st_reset_wen", wen, 1);     check("st_reset_mreq", mreq, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(OP_ST, 9'o777, 1, 0, 0);
        check("post_reset_rst_mreq", mreq, 0);
        cyc(OP_ST, 9'o777, 1, 0, 0);
        check("post_reset_inf_il", il, 1);

        // Randomized traffic
        stall = 0; fault_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            fault_cycles = (ph == P_FAULT) ? fault_cycles + 1 : 0;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0 || fault_cycles > 3) rst_n = 1'b0;
            if (ph == P_FETCH || ph == P_RESET) begin
                sel = $urandom_range(0, 99);
                if (sel < 3)       op = bad_ops[$urandom_range(0, 3)];
                else if (sel < 8)  op = OP_HAL;
                else begin
                    sel = $urandom_range(0, 24);
                    if (sel < 14)      op = alu_ops[sel];
                    else if (sel < 18) op = imm_ops[sel - 14];
                    else if (sel < 22) op = mem_ops[sel - 18];
                    else               op = br_ops[sel - 22];
                end
                ins  = {op, 9'($urandom)};
                ins2 = {op, 1'b0, 12'($urandom)};
            end
            if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else begin
                rdy = ($urandom_range(0, 99) < 70);
                if ($urandom_range(0, 49) == 0) stall = $urandom_range(5, 20);
            end
            nz  = 2'($urandom);
            run = ($urandom_range(0, 3) == 0);
        end

        @(negedge clk); #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cu_mc.md
CU_MC -- requirements
Module: cu_mc

Interface
REQ-001 SHALL take parameter IW, default 16: instruction width; opcode is ins_in[IW-1:IW-7], decoded as mycpu_pkg::opcode_t.
REQ-002 SHALL take parameter RAW, default 3: register-address width; DR=ins_in[3*RAW-1:2*RAW], SA=ins_in[2*RAW-1:RAW], SB=ins_in[RAW-1:0].
REQ-003 SHALL take parameter RSW, default 4: per-field width of rs_out; RSW>=RAW and IW>=7+3*RAW, both checked at elaboration.
REQ-004 SHALL take parameter WAIT_MAX, default 15: maximum wait cycles for a memory/IO handshake before fault.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 ins_in  in  IW  current instruction register contents.
REQ-008 nz_in  in  2  status flags {N,Z}.
REQ-009 mem_rdy_in  in  1  memory/IO ready; completes the pending access in the cycle it is high.
REQ-010 run_in  in  1  resume request from HLT.
REQ-011 il_out  out  1  instruction-register load.
REQ-012 ps_out  out  2  PC select: 00 hold, 01 increment, 10 branch offset, 11 jump.
REQ-013 rw_out  out  1  register-file write enable.
REQ-014 rs_out  out  3*RSW  {DR,SA,SB}, each zero-extended to RSW bits.
REQ-015 mx_out  out  4  datapath mux selects; fs_out out fs_t ALU function.
REQ-016 wen_out  out  1  memory/IO write enable, active-low; iom_out out 1 IO-space select.
REQ-017 mreq_out  out  1  access request; halted_out out 1 in HLT; fault_out out 1 in FLT.

Function
REQ-018 SHALL implement states RST, INF, EX0, MEMW, HLT, FLT in a registered state machine with combinational outputs.
REQ-019 Idle output set: ps 00, il 0, rw 0, rs 0, mx 0000, fs FMOVA, wen 1, iom 0, mreq 0; SHALL be driven in every state and case not specified below.
REQ-020 RST: idle outputs; next state INF unconditionally.
REQ-021 INF: mreq 1; il 1 only while mem_rdy_in=1; go to EX0 on mem_rdy_in=1, otherwise stay in INF.
REQ-022 Wait counter, log2(WAIT_MAX+1) bits: cleared on entry to INF/MEMW and on every ready cycle; increments per non-ready cycle in INF/MEMW; at WAIT_MAX with mem_rdy_in=0 the next state is FLT.
REQ-023 EX0 SHALL drive rs_out from the DR/SA/SB fields in every case.
REQ-024 Register ALU ops MOVA INC ADD MUL SUB DEC AND OR XOR NOT MOVB SHR SHL USR: ps 01, rw 1, mx 0100, fs as named (FMOVA..FUSR); next state INF.
REQ-025 Immediate ops SRA/SLA/LDI/ADI: ps 01, rw 1, mx 1100, fs FSRA/FSLA/FMOVB/FADD; next state INF.
REQ-026 Memory ops LD (mx 0010, rw), ST (wen 0), IOR (iom, rw), IOW (iom, wen 0): mreq 1 in EX0.
REQ-027 A memory op SHALL assert its commit strobes (rw or wen 0) and ps 01 only in the cycle mem_rdy_in=1, then go to INF; otherwise go to MEMW with strobes deasserted and ps 00.
REQ-028 MEMW: re-decodes ins_in, holds mreq, mx and iom; commits as in REQ-027 on mem_rdy_in=1, else remains in MEMW subject to REQ-022.
REQ-029 Branches: BRZ ps 10 if nz_in[0] else 01; BRN ps 10 if nz_in[1] else 01; JMP ps 11; rw 0; next state INF.
REQ-030 HAL: idle outputs, next state HLT; HLT: halted_out 1, go to INF on run_in=1, else stay.
REQ-031 Undefined opcode or state encoding: next state FLT; FLT holds idle outputs with fault_out 1 until reset.

Reset
REQ-032 rst_n low SHALL force state RST and clear the wait counter asynchronously, including mid-MEMW; an uncommitted access is abandoned with no rw/wen strobe.
REQ-033 After rst_n deassertion: one RST cycle, then INF.

Verification
REQ-034 ADD R1,R2,R3 with mem_rdy_in tied 1: INF il 1 -> EX0 rs_out=0x123, mx 0100, fs FADD, rw 1, ps 01 -> INF.
REQ-035 LD with ready delayed 3 cycles: EX0 then 3 MEMW cycles with rw 0, ps 00; rw 1, ps 01 only in the ready cycle.
REQ-036 Fetch with mem_rdy_in held 0, WAIT_MAX=15: FLT entered after 16 INF cycles, fault_out 1, stays in FLT until rst_n pulse.
REQ-037 BRZ with nz_in=01 -> ps 10; nz_in=10 -> ps 01; BRN with nz_in=10 -> ps 10.
REQ-038 HAL -> halted_out 1 for N cycles; run_in pulse -> INF with il 1 on the next ready cycle.
REQ-039 rst_n asserted during ST in MEMW: wen stays 1; after release the sequence is RST then INF; RAW=4, RSW=5 build gives rs_out width 15.
